// File: rtl/mux_arb_pkg.sv
// Shared constants and elaboration helpers for the mux_arb_nx1 selector/arbiter.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel-index width, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_nx1_rr_pick.sv
// Round-robin pick: first requesting channel after last_gnt, wrapping to channel 0.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_gnt,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_vld
);

    logic [SEL_W-1:0] hi_gnt;
    logic             hi_vld;
    logic [SEL_W-1:0] lo_gnt;
    logic             lo_vld;

    // The rotation is split into two fixed-priority scans: channels above
    // last_gnt win first, otherwise the lowest requester wraps around.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hi_gnt = '0;
        hi_vld = 1'b0;
        lo_gnt = '0;
        lo_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hi_vld && req[i] && (SEL_W'(i) > last_gnt)) begin
                hi_vld = 1'b1;
                hi_gnt = SEL_W'(i);
            end
            if (!lo_vld && req[i]) begin
                lo_vld = 1'b1;
                lo_gnt = SEL_W'(i);
            end
        end
    end

    assign gnt     = hi_vld ? hi_gnt : lo_gnt;
    assign gnt_vld = hi_vld | lo_vld;

endmodule

// File: rtl/mux_arb_nx1.sv
// N-channel selector/arbiter with a registered single-entry output stage.
// Define MUX_ARB_LOCK_EN to add IN_LAST and hold round-robin grants for whole packets.
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       IN_VALID,
    input  logic [NUM_CH*WIDTH-1:0] IN_DATA,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_CH-1:0]       IN_LAST,
`endif
    output logic [NUM_CH-1:0]       IN_READY,
    input  logic                    MODE,
    input  logic [SEL_W-1:0]        S,
    output logic                    OUT_VALID,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [SEL_W-1:0]        OUT_CH,
    input  logic                    OUT_READY
);

    logic [SEL_W-1:0] last_gnt;
    logic [SEL_W-1:0] rr_gnt;
    logic             rr_vld;
    logic [SEL_W-1:0] gnt;
    logic             gnt_vld;
    logic             fixed_vld;
    logic [WIDTH-1:0] sel_data;
    logic             load_en;
    logic             xfer;

`ifdef MUX_ARB_LOCK_EN
    logic             lock_q;
    logic [SEL_W-1:0] lock_ch;
    logic             lock_vld;
    logic             gnt_last;
`endif

    // Out-of-range selectors match no channel and therefore read as 0.
    function automatic logic bit_at(input logic [NUM_CH-1:0] v,
                                    input logic [SEL_W-1:0]  sel);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) r = v[i];
        end
        return r;
    endfunction

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req      (IN_VALID),
        .last_gnt (last_gnt),
        .gnt      (rr_gnt),
        .gnt_vld  (rr_vld)
    );

    assign fixed_vld = bit_at(IN_VALID, S);

`ifdef MUX_ARB_LOCK_EN
    assign lock_vld = bit_at(IN_VALID, lock_ch);
    assign gnt_last = bit_at(IN_LAST, gnt);
`endif

    always_comb begin
        gnt     = rr_gnt;
        gnt_vld = rr_vld;
        if (MODE == MODE_FIXED) begin
            gnt     = S;
            gnt_vld = fixed_vld;
        end
`ifdef MUX_ARB_LOCK_EN
        else if (lock_q) begin
            // A locked channel that drops valid simply stalls; nobody else gets in.
            gnt     = lock_ch;
            gnt_vld = lock_vld;
        end
`endif
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) sel_data = IN_DATA[i*WIDTH +: WIDTH];
        end
    end

    assign load_en = !OUT_VALID || OUT_READY;
    assign xfer    = !RST && load_en && gnt_vld;

    always_comb begin
        IN_READY = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            IN_READY[i] = xfer && (gnt == SEL_W'(i));
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
            last_gnt  <= SEL_W'(NUM_CH - 1);
`ifdef MUX_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else begin
            if (load_en) begin
                OUT_VALID <= gnt_vld;
                if (gnt_vld) begin
                    OUT_DATA <= sel_data;
                    OUT_CH   <= gnt;
                end
            end
            // Only round-robin transfers advance fairness state.
            if (xfer && (MODE == MODE_RR)) begin
                last_gnt <= gnt;
`ifdef MUX_ARB_LOCK_EN
                lock_q   <= !gnt_last;
                lock_ch  <= gnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Scoreboard bench for mux_arb_nx1: directed stimulus pushes expected beats, a monitor pops them.
module tb_mux_arb_nx1;
    import mux_arb_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  s;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;

    // Second instance with a non-power-of-two channel count to reach S >= NUM_CH.
    logic [4:0]     v5;
    logic [39:0]    d5;
    logic [4:0]     last5;
    logic [4:0]     r5;
    logic           m5;
    logic [2:0]     s5;
    logic           ov5;
    logic [7:0]     od5;
    logic [2:0]     oc5;
    logic           ordy5;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [W-1:0]  data;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 CLK = ~CLK;

    mux_arb_nx1 #(.WIDTH(W), .NUM_CH(N)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
`ifdef MUX_ARB_LOCK_EN
        .IN_LAST   (in_last),
`endif
        .IN_READY  (in_ready),
        .MODE      (mode),
        .S         (s),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_CH    (out_ch),
        .OUT_READY (out_ready)
    );

    mux_arb_nx1 #(.WIDTH(8), .NUM_CH(5)) u_dut5 (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (v5),
        .IN_DATA   (d5),
`ifdef MUX_ARB_LOCK_EN
        .IN_LAST   (last5),
`endif
        .IN_READY  (r5),
        .MODE      (m5),
        .S         (s5),
        .OUT_VALID (ov5),
        .OUT_DATA  (od5),
        .OUT_CH    (oc5),
        .OUT_READY (ordy5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] d);
        in_data[ch*W +: W] = d;
    endtask

    task automatic push(input int ch, input logic [W-1:0] d);
        beat_t b;
        b.ch   = SW'(ch);
        b.data = d;
        sb.push_back(b);
    endtask

    // Monitor: every handshake on the output port consumes one expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got ch %0d data %0h, expected no beat", out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_ch", 64'(out_ch), 64'(e.ch));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        mode      = MODE_FIXED;
        s         = '0;
        in_valid  = '1;
        in_data   = '0;
        in_last   = '1;
        out_ready = 1'b0;
        v5        = '0;
        d5        = '0;
        last5     = '1;
        m5        = MODE_FIXED;
        s5        = '0;
        ordy5     = 1'b1;

        // Reset: no channel readied even with every valid high.
        step();
        check("ready_in_reset", 64'(in_ready), 64'h0);
        step();
        RST      = 1'b0;
        in_valid = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_ch", 64'(out_ch), 64'h0);

        // Fixed select of channel 2.
        mode      = MODE_FIXED;
        s         = 2'd2;
        set_data(2, 32'hDEADBEEF);
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        check("fixed_ready", 64'(in_ready), 64'h4);
        push(2, 32'hDEADBEEF);
        step();
        in_valid = '0;
        check("fixed_out_valid", 64'(out_valid), 64'h1);
        step();

        // Back-pressure: ch1 loads, held three cycles, then ch3 follows.
        mode = MODE_RR;
        set_data(1, 32'hA1A1_0001);
        set_data(3, 32'hA3A3_0003);
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        check("bp_first_ready", 64'(in_ready), 64'h2);
        push(1, 32'hA1A1_0001);
        step();
        in_valid  = 4'b1000;
        out_ready = 1'b0;
        push(3, 32'hA3A3_0003);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_hold_ready", 64'(in_ready), 64'h0);
            check("bp_hold_valid", 64'(out_valid), 64'h1);
            check("bp_hold_ch", 64'(out_ch), 64'h1);
            check("bp_hold_data", 64'(out_data), 64'hA1A1_0001);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'h8);
        step();
        in_valid = '0;
        step();

        // Round-robin, all channels valid: 0,1,2,3,0,1 back to back.
        for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + W'(i));
        in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            push(k % N, 32'h1000_0000 + W'(k % N));
            #1;
            check("rr_ready", 64'(in_ready), 64'(4'b0001 << (k % N)));
            step();
        end
        in_valid = '0;
        step();

        // Selector beyond the channel count never readies anything.
        v5 = 5'b11111;
        d5 = 40'hA4_A3_A2_A1_A0;
        s5 = 3'd5;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) s5 = 3'd7;
            #1;
            check("oob_ready", 64'(r5), 64'h0);
            check("oob_out_valid", 64'(ov5), 64'h0);
            step();
        end
        s5 = 3'd4;
        #1;
        check("top_ch_ready", 64'(r5), 64'h10);
        step();
        v5 = '0;
        check("top_ch_valid", 64'(ov5), 64'h1);
        check("top_ch_ch", 64'(oc5), 64'h4);
        check("top_ch_data", 64'(od5), 64'hA4);

        // Reset with a beat stuck in the output register.
        set_data(0, 32'hC0C0_0000);
        set_data(2, 32'hC2C2_0002);
        in_valid  = 4'b0101;
        out_ready = 1'b0;
        #1;
        check("pre_rst_ready", 64'(in_ready), 64'h4);
        step();
        check("pre_rst_loaded", 64'(out_valid), 64'h1);
        RST = 1'b1;
        #1;
        check("mid_rst_ready", 64'(in_ready), 64'h0);
        step();
        RST = 1'b0;
        #1;
        check("post_rst_valid", 64'(out_valid), 64'h0);
        check("post_rst_data", 64'(out_data), 64'h0);
        check("post_rst_ch", 64'(out_ch), 64'h0);
        out_ready = 1'b1;
        #1;
        check("post_rst_grant", 64'(in_ready), 64'h1);
        push(0, 32'hC0C0_0000);
        step();
        in_valid = '0;
        step();

`ifdef MUX_ARB_LOCK_EN
        // Packet lock: ch1 sends three beats while ch0 and ch2 wait.
        set_data(0, 32'hE0E0_0000);
        set_data(2, 32'hE2E2_0002);
        set_data(1, 32'hB1B1_0000);
        in_last  = 4'b1101;
        in_valid = 4'b0111;
        #1;
        check("lock_beat0_ready", 64'(in_ready), 64'h2);
        push(1, 32'hB1B1_0000);
        step();
        set_data(1, 32'hB1B1_0001);
        #1;
        check("lock_beat1_ready", 64'(in_ready), 64'h2);
        push(1, 32'hB1B1_0001);
        step();
        set_data(1, 32'hB1B1_0002);
        in_last = 4'b1111;
        #1;
        check("lock_beat2_ready", 64'(in_ready), 64'h2);
        push(1, 32'hB1B1_0002);
        step();
        in_valid = 4'b0101;
        #1;
        check("lock_after_ch2", 64'(in_ready), 64'h4);
        push(2, 32'hE2E2_0002);
        step();
        in_valid = 4'b0001;
        #1;
        check("lock_after_ch0", 64'(in_ready), 64'h1);
        push(0, 32'hE0E0_0000);
        step();
        in_valid = '0;
        step();
`endif

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
